// File: rtl/capp_tag_resolver.sv
// Tag register and multiple-response resolver for the CAPP cell array.
// Captures match lines as word tags and steps through responders lowest-index first.
module capp_tag_resolver #(
  parameter int WORDS = 100,
  parameter int IDXW  = $clog2(WORDS),
  parameter int CNTW  = $clog2(WORDS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WORDS-1:0] match_lines,
  input  logic             set,
  input  logic             load,
  input  logic             and_load,
  input  logic             select_first,
  input  logic             next,
  output logic [WORDS-1:0] tag_wires,
  output logic             some_tag,
  output logic [IDXW-1:0]  first_idx,
  output logic [CNTW-1:0]  resp_count,
  output logic             done
);

  logic [WORDS-1:0] r_tags;
  logic             r_done;

  logic [WORDS-1:0] w_lowest;
  logic [WORDS-1:0] w_cleared;
  logic             w_some;
  logic             w_single;
  logic [IDXW-1:0]  w_first;
  logic [CNTW-1:0]  w_count;

  // Two's-complement tricks: x & -x isolates the lowest set bit,
  // x & (x-1) clears it. Both yield 0 when x is 0.
  always_comb begin
    w_lowest  = r_tags & (~r_tags + WORDS'(1));
    w_cleared = r_tags & (r_tags - WORDS'(1));
    w_some    = |r_tags;
    w_single  = w_some && (w_cleared == '0);
  end

  always_comb begin
    w_first = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (r_tags[i]) w_first = IDXW'(i);
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_count = w_count + CNTW'(r_tags[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tags <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (set) begin
        r_tags <= '1;
      end else if (load) begin
        r_tags <= match_lines;
      end else if (and_load) begin
        r_tags <= r_tags & match_lines;
      end else if (select_first) begin
        r_tags <= w_lowest;
      end else if (next) begin
        r_tags <= w_cleared;
        r_done <= w_single;
      end
    end
  end

  assign tag_wires  = r_tags;
  assign some_tag   = w_some;
  assign first_idx  = w_first;
  assign resp_count = w_count;
  assign done       = r_done;

endmodule

// File: tb/tb_capp_tag_resolver.sv
// Randomized and directed check of capp_tag_resolver against a per-word array model.
module tb_capp_tag_resolver;

  localparam int W    = 100;
  localparam int IDXW = $clog2(W);
  localparam int CNTW = $clog2(W + 1);

  logic            CLK = 1'b0;
  logic            RST;
  logic [W-1:0]    match_lines;
  logic            set, load, and_load, select_first, next;
  logic [W-1:0]    tag_wires;
  logic            some_tag;
  logic [IDXW-1:0] first_idx;
  logic [CNTW-1:0] resp_count;
  logic            done;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  bit m_tags[W];
  bit m_done;

  capp_tag_resolver #(.WORDS(W)) dut (
    .CLK(CLK), .RST(RST), .match_lines(match_lines),
    .set(set), .load(load), .and_load(and_load),
    .select_first(select_first), .next(next),
    .tag_wires(tag_wires), .some_tag(some_tag), .first_idx(first_idx),
    .resp_count(resp_count), .done(done)
  );

  always #5 CLK = ~CLK;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(m_tags[i]);
    return c;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < W; i++) if (m_tags[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] m_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = m_tags[i];
    return v;
  endfunction

  task automatic model_step(input bit r, s, l, a, sf, n, input logic [W-1:0] ml);
    int k;
    int c;
    m_done = 0;
    if (r) begin
      for (int i = 0; i < W; i++) m_tags[i] = 0;
    end else if (s) begin
      for (int i = 0; i < W; i++) m_tags[i] = 1;
    end else if (l) begin
      for (int i = 0; i < W; i++) m_tags[i] = ml[i];
    end else if (a) begin
      for (int i = 0; i < W; i++) m_tags[i] = m_tags[i] & ml[i];
    end else if (sf) begin
      k = m_lowest();
      for (int i = 0; i < W; i++) m_tags[i] = (i == k);
    end else if (n) begin
      c = m_count();
      k = m_lowest();
      if (k >= 0) m_tags[k] = 0;
      m_done = (c == 1);
    end
  endtask

  task automatic check_int(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_vec(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      int k;
      k = m_lowest();
      check_vec("tag_wires", tag_wires, m_vec());
      check_int("some_tag", some_tag, (m_count() != 0));
      check_int("first_idx", first_idx, (k < 0) ? 0 : k);
      check_int("resp_count", resp_count, m_count());
      check_int("done", done, m_done);
    end
  end

  task automatic cyc(input bit r, s, l, a, sf, n, input logic [W-1:0] ml);
    RST = r; set = s; load = l; and_load = a; select_first = sf; next = n;
    match_lines = ml;
    @(posedge CLK);
    model_step(r, s, l, a, sf, n, ml);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_vec();
    logic [127:0] x;
    x = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 1) == 1) x = x & {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 2) == 0) x = x & {$urandom, $urandom, $urandom, $urandom};
    return x[W-1:0];
  endfunction

  logic [W-1:0] e;
  logic [W-1:0] z;

  initial begin
    z = '0;
    RST = 1'b1; set = 1'b0; load = 1'b0; and_load = 1'b0;
    select_first = 1'b0; next = 1'b0; match_lines = '0;

    // Reset held two cycles with set asserted.
    cyc(1, 1, 0, 0, 0, 0, z);
    cyc(1, 1, 0, 0, 0, 0, z);
    chk_en = 1;
    check_vec("rst_tags", tag_wires, z);
    check_int("rst_some", some_tag, 0);
    check_int("rst_first", first_idx, 0);
    check_int("rst_count", resp_count, 0);
    check_int("rst_done", done, 0);

    // Load {3,7,64}
    e = '0; e[3] = 1'b1; e[7] = 1'b1; e[64] = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, e);
    check_vec("load_tags", tag_wires, e);
    check_int("load_count", resp_count, 3);
    check_int("load_first", first_idx, 3);
    check_int("load_some", some_tag, 1);

    // Narrow with {7,64,99}
    e = '0; e[7] = 1'b1; e[64] = 1'b1; e[99] = 1'b1;
    cyc(0, 0, 0, 1, 0, 0, e);
    e = '0; e[7] = 1'b1; e[64] = 1'b1;
    check_vec("and_tags", tag_wires, e);
    check_int("and_count", resp_count, 2);
    check_int("and_first", first_idx, 7);

    // Iterate over {3,7,64}
    e = '0; e[3] = 1'b1; e[7] = 1'b1; e[64] = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, e);
    cyc(0, 0, 0, 0, 0, 1, z);
    check_int("it1_first", first_idx, 7);
    check_int("it1_done", done, 0);
    cyc(0, 0, 0, 0, 0, 1, z);
    check_int("it2_first", first_idx, 64);
    check_int("it2_done", done, 0);
    cyc(0, 0, 0, 0, 0, 1, z);
    check_int("it3_some", some_tag, 0);
    check_int("it3_done", done, 1);
    cyc(0, 0, 0, 0, 0, 1, z);
    check_int("it4_some", some_tag, 0);
    check_int("it4_done", done, 0);

    // Priority: set, then select_first+next, then set+load
    cyc(0, 1, 0, 0, 0, 0, z);
    check_int("set_count", resp_count, 100);
    check_int("set_first", first_idx, 0);
    cyc(0, 0, 0, 0, 1, 1, z);
    e = '0; e[0] = 1'b1;
    check_vec("sel_tags", tag_wires, e);
    check_int("sel_done", done, 0);
    cyc(0, 1, 1, 0, 0, 0, z);
    check_vec("setload_tags", tag_wires, ~z);

    // Reset in the middle of iteration
    e = '0; e[5] = 1'b1; e[9] = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, e);
    cyc(0, 0, 0, 0, 0, 1, z);
    check_int("mid_first", first_idx, 9);
    cyc(1, 0, 0, 0, 0, 1, z);
    check_vec("mid_rst_tags", tag_wires, z);
    check_int("mid_rst_done", done, 0);
    cyc(0, 0, 0, 0, 0, 1, z);
    check_vec("mid_next_tags", tag_wires, z);
    check_int("mid_next_count", resp_count, 0);
    check_int("mid_next_done", done, 0);

    // Randomized traffic; next is favoured so iterations run to completion.
    for (int t = 0; t < 1500; t++) begin
      bit r, s, l, a, sf, n;
      r  = ($urandom_range(0, 79) == 0);
      s  = ($urandom_range(0, 24) == 0);
      l  = ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 9) == 0);
      sf = ($urandom_range(0, 11) == 0);
      n  = ($urandom_range(0, 2) != 0);
      cyc(r, s, l, a, sf, n, rnd_vec());
    end

    cyc(0, 0, 0, 0, 0, 0, z);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capp_tag_resolver.md
# capp_tag_resolver

Tag register and multiple-response resolver for the content-addressable parallel processor array. Sits directly downstream of the cell array: it captures the per-word match lines produced by a compare/search, holds them as word tags, and resolves multiple responders by selecting or iterating over tagged words lowest-index first. Its tag outputs drive the word-select (write/read enable) side of the array for subsequent parallel operations.

## Interface
- WORDS, 100, number of words in the cell array (one match line and one tag per word); 2..1024
- IDXW, $clog2(WORDS), width of word index outputs
- CNTW, $clog2(WORDS+1), width of responder count
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- match_lines  input  WORDS  per-word match result from the cell array; bit i = word i matched
- set  input  1  strobe: tag every word
- load  input  1  strobe: tags <= match_lines
- and_load  input  1  strobe: tags <= tags & match_lines (search narrowing)
- select_first  input  1  strobe: keep only the lowest-index tag
- next  input  1  strobe: clear the lowest-index tag (step to next responder)
- tag_wires  output  WORDS  current tag register
- some_tag  output  1  |tag_wires
- first_idx  output  IDXW  index of lowest set tag; 0 when no tag set
- resp_count  output  CNTW  number of set tags
- done  output  1  one-cycle pulse: a `next` cleared the last remaining tag

## Operation
- Single WORDS-bit tag register; all outputs derive from it (plus the registered done flag).
- Command priority when several strobes are high in one cycle: RST > set > load > and_load > select_first > next. Only the highest-priority command takes effect; the others are dropped, not queued.
- set: tags <= all ones.
- load: tags <= match_lines (sampled the same edge).
- and_load: tags <= tags & match_lines.
- select_first: tags <= one-hot of the lowest set bit; if tags == 0, stays 0.
- next: lowest set bit cleared; if tags == 0, no effect and done stays 0.
- done: registered; 1 in the cycle after a `next` takes effect when tags had exactly one bit set; 0 after every other edge.
- No command: tags hold.
- first_idx: priority encoder, bit 0 highest priority.
- resp_count: popcount of tags, unsigned, CNTW bits; reaches WORDS after set without overflow.

## Timing
- Reset (RST high at edge): tags = 0, some_tag = 0, first_idx = 0, resp_count = 0, done = 0. RST overrides any concurrent strobe.
- Command latency: 1 cycle; tag_wires reflects a command issued on edge N immediately after edge N.
- some_tag, first_idx, resp_count: combinational from the tag register, valid the same cycle as tag_wires (no extra latency); no combinational path from any input to any output.
- done: asserted for exactly one cycle following the edge on which the last tag was cleared by `next`.
- match_lines sampled only on edges where load or and_load wins priority; it must be stable at those edges (upstream search settles beforehand).
- Back-to-back next strobes on consecutive cycles step one responder per cycle; N responders exhausted in N cycles, done on the cycle after the N-th.
- RST asserted mid-iteration: tags cleared at that edge, done = 0; subsequent next is a no-op until tags reloaded.

## Test plan
- Reset: hold RST 2 cycles with set=1 -> tag_wires=0, some_tag=0, first_idx=0, resp_count=0, done=0.
- Load/count: WORDS=100, match_lines bits {3,7,64} set, pulse load -> next cycle tag_wires has bits 3,7,64, resp_count=3, first_idx=3, some_tag=1.
- Narrowing: after above, match_lines bits {7,64,99}, pulse and_load -> tags {7,64}, resp_count=2, first_idx=7.
- Iteration: tags {3,7,64}, next held 4 cycles -> first_idx 7, 64, then some_tag=0; done=1 only in cycle after third next; fourth next no effect, done=0.
- Select/priority: set -> resp_count=100, first_idx=0; then assert select_first and next together -> tags only bit 0 (select_first wins); then set and load together -> all ones (set wins).
- Mid-operation reset: tags {5,9}, next then RST on following edge -> tags=0, done=0; next afterwards leaves all outputs 0.
